// File: rtl/tamarisc_pkg.sv
// Shared types and constants for the tamarisc front end.
package tamarisc_pkg;

    localparam int XLEN = 32;

    // Canonical NOP (addi x0, x0, 0), presented whenever the fetch output is empty.
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_skid.sv
// One-entry skid buffer holding a fetched instruction and its PC.
// Clear has priority over push. Push has priority over pop, so a
// simultaneous push and pop replaces the entry.
module fetch_skid
    import tamarisc_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         clear,
    input  logic         push,
    input  logic         pop,
    input  fetch_entry_t din,
    output logic         full,
    output fetch_entry_t dout
);

    logic         full_reg;
    fetch_entry_t entry_reg;

    // Occupancy flag and stored entry.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            full_reg  <= 1'b0;
            entry_reg <= '0;
        end else if (clear) begin
            full_reg <= 1'b0;
        end else if (push) begin
            full_reg  <= 1'b1;
            entry_reg <= din;
        end else if (pop) begin
            full_reg <= 1'b0;
        end
    end

    assign full = full_reg;
    assign dout = entry_reg;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: issues one memory request at a time, and
// returns instructions with their PC through an output slot backed by
// a one-entry skid buffer. A flush drops everything in flight.
module fetch_stage
    import tamarisc_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic [XLEN-1:0] pc_i,
    output logic            incr_pc_o,
    input  logic            flush_i,
    input  logic            stall_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [XLEN-1:0] imem_rdata_i,
    output logic            instr_valid_o,
    output logic [XLEN-1:0] instr_o,
    output logic [XLEN-1:0] instr_pc_o
);

    fetch_state_e    state_reg;
    logic [XLEN-1:0] req_pc_reg;
    logic            slot_valid_reg;
    fetch_entry_t    slot_reg;

    logic         skid_full;
    fetch_entry_t skid_dout;
    logic         skid_push;
    logic         skid_pop;
    logic         skid_full_next;
    logic         resp_live;
    logic         slot_load;
    logic         can_issue;
    fetch_entry_t resp_entry;

    // A response is kept only when it answers a live request and no flush is pending.
    assign resp_live  = (state_reg == WAIT) && imem_rvalid_i && !flush_i;
    assign resp_entry = '{instr: imem_rdata_i, pc: req_pc_reg};

    // An empty slot may always be filled; a valid one only when downstream takes it.
    assign slot_load = !stall_i || !slot_valid_reg;

    // Skid drains into the slot first so program order is kept; a response
    // lands in the skid when the slot is blocked or the skid is ahead of it.
    assign skid_pop       = skid_full && slot_load;
    assign skid_push      = resp_live && (skid_full || !slot_load);
    assign skid_full_next = skid_push || (skid_full && !skid_pop);

    // Only request when nothing is outstanding, or the outstanding one returns now,
    // and there is guaranteed room for the answer.
    assign can_issue   = (state_reg == IDLE) || ((state_reg == WAIT) && imem_rvalid_i);
    assign imem_req_o  = rst_n_i && !flush_i && !skid_full_next && can_issue;
    assign imem_addr_o = pc_i;
    assign incr_pc_o   = imem_req_o && imem_gnt_i && !flush_i;

    fetch_skid u_skid (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .clear   (flush_i),
        .push    (skid_push),
        .pop     (skid_pop),
        .din     (resp_entry),
        .full    (skid_full),
        .dout    (skid_dout)
    );

    // Request tracking FSM and the PC of the outstanding request.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_reg  <= IDLE;
            req_pc_reg <= '0;
        end else begin
            if (incr_pc_o) begin
                req_pc_reg <= pc_i;
            end
            unique case (state_reg)
                IDLE: begin
                    if (incr_pc_o) begin
                        state_reg <= WAIT;
                    end
                end
                WAIT: begin
                    // incr_pc_o is already low under flush, so a flushed response ends in IDLE.
                    if (imem_rvalid_i) begin
                        state_reg <= incr_pc_o ? WAIT : IDLE;
                    end else if (flush_i) begin
                        state_reg <= DRAIN;
                    end
                end
                DRAIN: begin
                    // The discarded response retires the drain even if another flush arrives with it.
                    if (imem_rvalid_i) begin
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Output slot: skid first, then a fresh response, else empty; held while stalled.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            slot_valid_reg <= 1'b0;
            slot_reg       <= '0;
        end else if (flush_i) begin
            slot_valid_reg <= 1'b0;
        end else if (slot_load) begin
            if (skid_full) begin
                slot_valid_reg <= 1'b1;
                slot_reg       <= skid_dout;
            end else if (resp_live) begin
                slot_valid_reg <= 1'b1;
                slot_reg       <= resp_entry;
            end else begin
                slot_valid_reg <= 1'b0;
            end
        end
    end

    assign instr_valid_o = slot_valid_reg;
    assign instr_o       = slot_valid_reg ? slot_reg.instr : NOP_INSTR;
    assign instr_pc_o    = slot_reg.pc;

endmodule
